// File: rtl/input_ctrl_sync.sv
// input_ctrl_sync: 4-phase receiver, 2-entry in-order FIFO, dest-masked routing to two 4-phase sender links
module input_ctrl_sync #(
    parameter int WIDTH_packet = 14,
    parameter int DEST_W = 3,
    parameter logic [DEST_W-1:0] MASK = 3'b001
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_req,
    input  logic [WIDTH_packet-1:0] in_data,
    output logic                    in_ack,
    output logic                    out0_req,
    output logic                    out1_req,
    output logic [WIDTH_packet-1:0] out0_data,
    output logic [WIDTH_packet-1:0] out1_data,
    input  logic                    out0_ack,
    input  logic                    out1_ack,
    output logic [15:0]             pkt_cnt0,
    output logic [15:0]             pkt_cnt1
);
    typedef enum logic {R_IDLE, R_HOLD} r_state_t;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} s_state_t;

    r_state_t r_state, r_next;
    s_state_t s_state [2];
    s_state_t s_next [2];
    logic [WIDTH_packet-1:0] mem [2];
    logic [WIDTH_packet-1:0] data [2];
    logic [DEST_W-1:0] dest;
    logic [1:0] count, ack, pop_p;
    logic rd_ptr, wr_ptr, push, pop, sel;

    assign ack = {out1_ack, out0_ack};
    assign dest = mem[rd_ptr][WIDTH_packet-1 -: DEST_W];
    assign sel = |(dest & MASK);
    assign pop = |pop_p;
    assign out0_data = data[0];
    assign out1_data = data[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= R_IDLE;
        else
            r_state <= r_next;
    end

    always_comb begin
        r_next = (r_state == R_IDLE) ? ((in_req && count != 2'd2) ? R_HOLD : R_IDLE)
                                     : (in_req ? R_HOLD : R_IDLE);
    end

    always_comb begin
        in_ack = r_state == R_HOLD;
        push = r_state == R_IDLE && in_req && count != 2'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                s_state[i] <= S_IDLE;
                data[i] <= '0;
            end
            pkt_cnt0 <= 16'd0;
            pkt_cnt1 <= 16'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                s_state[i] <= s_next[i];
                if (pop_p[i]) data[i] <= mem[rd_ptr];
            end
            if (s_state[0] == S_REL && !ack[0]) pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (s_state[1] == S_REL && !ack[1]) pkt_cnt1 <= pkt_cnt1 + 16'd1;
        end
    end

    // only the head can leave, and only toward the port it decodes to
    always_comb begin
        pop_p = '0;
        for (int i = 0; i < 2; i++) begin
            pop_p[i] = count != 2'd0 && sel == 1'(i) && s_state[i] == S_IDLE && !ack[i];
            s_next[i] = (s_state[i] == S_IDLE) ? (pop_p[i] ? S_REQ : S_IDLE) :
                        (s_state[i] == S_REQ)  ? (ack[i] ? S_REL : S_REQ) :
                                                 (ack[i] ? S_REL : S_IDLE);
        end
    end

    always_comb begin
        out0_req = s_state[0] == S_REQ;
        out1_req = s_state[1] == S_REQ;
    end
endmodule

// File: tb/tb_input_ctrl_sync.sv
// tb_input_ctrl_sync: directed timing scenarios plus randomized traffic checked against a per-port queue model
module tb_input_ctrl_sync;
    logic clk, rst_n, in_req, in_ack, out0_req, out1_req, out0_ack, out1_ack;
    logic [13:0] in_data, out0_data, out1_data;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic [15:0] exp_cnt0, exp_cnt1;
    logic [13:0] got0[$];
    logic [13:0] got1[$];
    int total = 0;
    int bad = 0;

    input_ctrl_sync dut (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
        .out0_req(out0_req), .out1_req(out1_req), .out0_data(out0_data), .out1_data(out1_data),
        .out0_ack(out0_ack), .out1_ack(out1_ack), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ack(input int p, input logic v);
        if (p == 1) out1_ack = v;
        else out0_ack = v;
    endtask

    task automatic send_pkt(input logic [13:0] d);
        int n = 0;
        in_data = d;
        in_req = 1'b1;
        do begin tick(); n++; end while (!in_ack && n < 100);
        if (!in_ack) begin
            total++; bad++;
            $display("FAIL send_timeout in_ack=%b want 1", in_ack);
        end
        in_req = 1'b0;
        tick();
    endtask

    task automatic finish_xfer(input int p, output logic [13:0] d, output bit ok);
        int k = 0;
        ok = 1'b1;
        d = '0;
        while (!(p == 1 ? out1_req : out0_req) && k < 50) begin tick(); k++; end
        if (!(p == 1 ? out1_req : out0_req)) begin
            ok = 1'b0;
            return;
        end
        d = (p == 1) ? out1_data : out0_data;
        set_ack(p, 1'b1);
        k = 0;
        do begin tick(); k++; end while ((p == 1 ? out1_req : out0_req) && k < 50);
        set_ack(p, 1'b0);
        tick();
        if (p == 1) exp_cnt1++;
        else exp_cnt0++;
    endtask

    task automatic respond(input int p, input int n_exp);
        int idle = 0;
        int k;
        while ((p == 1 ? got1.size() : got0.size()) < n_exp && idle < 3000) begin
            if (p == 1 ? out1_req : out0_req) begin
                if (p == 1) got1.push_back(out1_data);
                else got0.push_back(out0_data);
                repeat ($urandom_range(0, 2)) tick();
                set_ack(p, 1'b1);
                k = 0;
                do begin tick(); k++; end while ((p == 1 ? out1_req : out0_req) && k < 50);
                repeat ($urandom_range(0, 2)) tick();
                set_ack(p, 1'b0);
                tick();
            end else begin
                tick();
                idle++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_req = 1'b0; in_data = '0; out0_ack = 1'b0; out1_ack = 1'b0;
        exp_cnt0 = '0; exp_cnt1 = '0;
        tick(); tick();
        total++;
        if ({in_ack, out0_req, out1_req, out0_data, out1_data, pkt_cnt0, pkt_cnt1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs ack=%b r0=%b r1=%b d0=%h d1=%h c0=%h c1=%h want all 0",
                     in_ack, out0_req, out1_req, out0_data, out1_data, pkt_cnt0, pkt_cnt1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_routing();
        logic [13:0] a = 14'b10100000100000;
        logic [13:0] b = 14'b01011111000000;
        logic [13:0] d;
        bit ok;
        send_pkt(a);
        send_pkt(b);
        total++;
        if (out1_data !== a || out1_req !== 1'b1) begin
            bad++; $display("FAIL route_p1 out1_data=%h req=%b want %h 1", out1_data, out1_req, a);
        end
        total++;
        if (out0_data !== b || out0_req !== 1'b1) begin
            bad++; $display("FAIL route_p0 out0_data=%h req=%b want %h 1", out0_data, out0_req, b);
        end
        finish_xfer(1, d, ok);
        finish_xfer(0, d, ok);
        total++;
        if (pkt_cnt1 !== 16'd1 || pkt_cnt0 !== 16'd1) begin
            bad++; $display("FAIL route_cnt c0=%0d c1=%0d want 1 1", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_latency();
        logic [13:0] p = {3'b001, 11'h2A5};
        logic [13:0] d;
        bit ok;
        in_data = p;
        in_req = 1'b1;
        tick();
        total++;
        if (in_ack !== 1'b1 || out1_req !== 1'b0) begin
            bad++; $display("FAIL lat_ingress in_ack=%b out1_req=%b want 1 0", in_ack, out1_req);
        end
        in_req = 1'b0;
        tick();
        total++;
        if (out1_req !== 1'b1 || out1_data !== p || in_ack !== 1'b0) begin
            bad++; $display("FAIL lat_cut out1_req=%b d=%h in_ack=%b want 1 %h 0", out1_req, out1_data, in_ack, p);
        end
        out1_ack = 1'b1;
        tick();
        total++;
        if (out1_req !== 1'b0) begin
            bad++; $display("FAIL lat_reqdrop out1_req=%b want 0", out1_req);
        end
        out1_ack = 1'b0;
        tick();
        exp_cnt1++;
        total++;
        if (pkt_cnt1 !== exp_cnt1) begin
            bad++; $display("FAIL lat_cnt pkt_cnt1=%0d want %0d", pkt_cnt1, exp_cnt1);
        end
    endtask

    task automatic test_full();
        logic [13:0] pk [4];
        logic [13:0] d;
        bit ok;
        for (int i = 0; i < 4; i++) pk[i] = {3'b000, 11'($urandom)};
        for (int i = 0; i < 3; i++) send_pkt(pk[i]);
        total++;
        if (out0_req !== 1'b1 || out0_data !== pk[0]) begin
            bad++; $display("FAIL full_head out0_data=%h req=%b want %h 1", out0_data, out0_req, pk[0]);
        end
        in_data = pk[3];
        in_req = 1'b1;
        repeat (3) begin
            tick();
            total++;
            if (in_ack !== 1'b0) begin bad++; $display("FAIL full_hold in_ack=%b want 0", in_ack); end
        end
        out0_ack = 1'b1;
        tick();
        total++;
        if (out0_req !== 1'b0 || in_ack !== 1'b0) begin
            bad++; $display("FAIL full_k out0_req=%b in_ack=%b want 0 0", out0_req, in_ack);
        end
        out0_ack = 1'b0;
        tick();
        exp_cnt0++;
        total++;
        if (in_ack !== 1'b0 || pkt_cnt0 !== exp_cnt0) begin
            bad++; $display("FAIL full_l in_ack=%b cnt=%0d want 0 %0d", in_ack, pkt_cnt0, exp_cnt0);
        end
        tick();
        total++;
        if (in_ack !== 1'b0 || out0_req !== 1'b1 || out0_data !== pk[1]) begin
            bad++; $display("FAIL full_pop in_ack=%b req=%b d=%h want 0 1 %h", in_ack, out0_req, out0_data, pk[1]);
        end
        tick();
        total++;
        if (in_ack !== 1'b1) begin bad++; $display("FAIL full_accept in_ack=%b want 1", in_ack); end
        in_req = 1'b0;
        tick();
        for (int i = 1; i < 4; i++) begin
            finish_xfer(0, d, ok);
            total++;
            if (!ok || d !== pk[i]) begin
                bad++; $display("FAIL full_order idx=%0d got=%h ok=%b want %h", i, d, ok, pk[i]);
            end
        end
    endtask

    task automatic test_hol();
        logic [13:0] x = {3'b001, 11'($urandom)};
        logic [13:0] y = {3'b011, 11'($urandom)};
        logic [13:0] z = {3'b110, 11'($urandom)};
        logic [13:0] d;
        bit ok;
        send_pkt(x);
        send_pkt(y);
        send_pkt(z);
        repeat (3) begin
            tick();
            total++;
            if (out0_req !== 1'b0 || out1_data !== x) begin
                bad++; $display("FAIL hol_block out0_req=%b out1_data=%h want 0 %h", out0_req, out1_data, x);
            end
        end
        out1_ack = 1'b1;
        tick();
        out1_ack = 1'b0;
        tick();
        exp_cnt1++;
        total++;
        if (out0_req !== 1'b0) begin bad++; $display("FAIL hol_l out0_req=%b want 0", out0_req); end
        tick();
        total++;
        if (out1_req !== 1'b1 || out1_data !== y || out0_req !== 1'b0) begin
            bad++; $display("FAIL hol_y out1_req=%b d=%h out0_req=%b want 1 %h 0", out1_req, out1_data, out0_req, y);
        end
        tick();
        total++;
        if (out0_req !== 1'b1 || out0_data !== z) begin
            bad++; $display("FAIL hol_z out0_req=%b d=%h want 1 %h", out0_req, out0_data, z);
        end
        finish_xfer(1, d, ok);
        finish_xfer(0, d, ok);
        total++;
        if (pkt_cnt0 !== exp_cnt0 || pkt_cnt1 !== exp_cnt1) begin
            bad++; $display("FAIL hol_cnt c0=%0d c1=%0d want %0d %0d", pkt_cnt0, pkt_cnt1, exp_cnt0, exp_cnt1);
        end
    endtask

    task automatic test_random();
        logic [13:0] pk [40];
        logic [13:0] exp0[$];
        logic [13:0] exp1[$];
        got0.delete();
        got1.delete();
        for (int i = 0; i < 40; i++) begin
            pk[i] = 14'($urandom);
            if ((pk[i][13:11] & 3'b001) != 3'b000) exp1.push_back(pk[i]);
            else exp0.push_back(pk[i]);
        end
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_pkt(pk[i]);
            end
            respond(0, exp0.size());
            respond(1, exp1.size());
        join
        total++;
        if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
            bad++; $display("FAIL rand_count got0=%0d got1=%0d want %0d %0d", got0.size(), got1.size(), exp0.size(), exp1.size());
        end
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
            total++;
            if (got0[i] !== exp0[i]) begin bad++; $display("FAIL rand_p0 idx=%0d got=%h want %h", i, got0[i], exp0[i]); end
        end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            total++;
            if (got1[i] !== exp1[i]) begin bad++; $display("FAIL rand_p1 idx=%0d got=%h want %h", i, got1[i], exp1[i]); end
        end
        exp_cnt0 += 16'(exp0.size());
        exp_cnt1 += 16'(exp1.size());
        tick();
        total++;
        if (pkt_cnt0 !== exp_cnt0 || pkt_cnt1 !== exp_cnt1) begin
            bad++; $display("FAIL rand_cnt c0=%0d c1=%0d want %0d %0d", pkt_cnt0, pkt_cnt1, exp_cnt0, exp_cnt1);
        end
    endtask

    task automatic test_wrap();
        logic [13:0] d;
        bit ok;
        #2;
        force dut.pkt_cnt0 = 16'hFFFF;
        #1;
        release dut.pkt_cnt0;
        exp_cnt0 = 16'hFFFF;
        tick();
        send_pkt({3'b010, 11'($urandom)});
        finish_xfer(0, d, ok);
        total++;
        if (pkt_cnt0 !== 16'h0000 || pkt_cnt0 !== exp_cnt0) begin
            bad++; $display("FAIL wrap pkt_cnt0=%h want 0000", pkt_cnt0);
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] p = {3'b100, 11'h155};
        logic [13:0] d;
        bit ok;
        for (int i = 0; i < 3; i++) send_pkt({3'b000, 11'($urandom) | 11'h1});
        total++;
        if (out0_req !== 1'b1) begin bad++; $display("FAIL rmid_pre out0_req=%b want 1", out0_req); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt0 = '0; exp_cnt1 = '0;
        total++;
        if ({in_ack, out0_req, out1_req, out0_data, out1_data, pkt_cnt0, pkt_cnt1} !== '0) begin
            bad++;
            $display("FAIL rmid_async ack=%b r0=%b r1=%b d0=%h d1=%h c0=%h c1=%h want all 0",
                     in_ack, out0_req, out1_req, out0_data, out1_data, pkt_cnt0, pkt_cnt1);
        end
        tick();
        rst_n = 1'b1;
        in_data = p;
        in_req = 1'b1;
        tick();
        total++;
        if (in_ack !== 1'b1) begin bad++; $display("FAIL rmid_accept in_ack=%b want 1", in_ack); end
        in_req = 1'b0;
        tick();
        total++;
        if (out0_req !== 1'b1 || out0_data !== p) begin
            bad++; $display("FAIL rmid_fresh out0_req=%b d=%h want 1 %h", out0_req, out0_data, p);
        end
        finish_xfer(0, d, ok);
        total++;
        if (pkt_cnt0 !== exp_cnt0) begin bad++; $display("FAIL rmid_cnt pkt_cnt0=%0d want %0d", pkt_cnt0, exp_cnt0); end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_latency();
        test_full();
        test_hol();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
